// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Valid/ready 1-to-2 stream demultiplexer for the multifunction barrel shifter
// datapath. Every accepted input word is steered by its in_sel bit to the left
// (in_sel = 0) or the right (in_sel = 1) output channel. Each channel has its
// own 2-entry FIFO. A stalled channel therefore never blocks the other one, and
// a channel that is not stalled runs at one word per cycle.
//
// Optional feature macro: STREAM_DEMUX_COUNT_EN
//   When defined, the left_count/right_count ports and their 8-bit wrapping
//   transfer counters exist. When undefined, both are absent.
//
// Ports
//   clk          rising-edge clock, the only clock
//   reset_n      synchronous active-low reset, sampled on rising clk
//   in_data      input word (WIDTH bits)
//   in_sel       steering bit (0 = left, 1 = right), qualified by in_valid
//   in_valid     input word present
//   in_ready     selected channel has room this cycle
//   left_data    head word of the left FIFO
//   left_valid   left FIFO not empty
//   left_ready   left consumer accepts the head word
//   right_data   head word of the right FIFO
//   right_valid  right FIFO not empty
//   right_ready  right consumer accepts the head word
//   left_count   completed left transfers, wraps at 256 (COUNT_EN only)
//   right_count  completed right transfers, wraps at 256 (COUNT_EN only)
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] left_data,
  output logic             left_valid,
  input  logic             left_ready,
  output logic [WIDTH-1:0] right_data,
  output logic             right_valid,
  input  logic             right_ready
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [7:0]       left_count,
  output logic [7:0]       right_count
`endif
);

  // Channel index. It matches the encoding of in_sel.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  localparam logic [1:0] OCC_FULL = 2'd2;

  // Per-channel FIFO state. The outer packed index is the channel.
  logic [1:0][1:0][WIDTH-1:0] mem;     // [channel][slot]
  logic [1:0][1:0]            occ;     // occupancy 0..2 per channel
  logic [1:0]                 rd_ptr;
  logic [1:0]                 wr_ptr;

  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] ch_valid;
  logic [1:0] ch_ready;

  assign ch_ready = {right_ready, left_ready};

  // in_ready depends only on in_sel and the current occupancies. A full channel
  // that pops in the same cycle still refuses the word, because there is no
  // pass-through from the output side. This keeps the output ready signals out
  // of the combinational in_ready path.
  assign in_ready = (occ[in_sel] != OCC_FULL);

  assign push[CH_LEFT]  = in_valid && in_ready && (in_sel == CH_LEFT);
  assign push[CH_RIGHT] = in_valid && in_ready && (in_sel == CH_RIGHT);

  assign ch_valid[CH_LEFT]  = (occ[CH_LEFT]  != 2'd0);
  assign ch_valid[CH_RIGHT] = (occ[CH_RIGHT] != 2'd0);

  assign pop = ch_valid & ch_ready;

  // NOTE: State updates use non-blocking assignments. Every register then sees
  // the pre-edge values of the others, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      // NOTE: The storage is reset along with the control state. After a reset
      // left_data/right_data read 0 rather than stale words. With only four
      // words of storage, resetting them costs almost nothing.
      mem    <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (push[ch]) begin
          mem[ch][wr_ptr[ch]] <= in_data;
          wr_ptr[ch]          <= ~wr_ptr[ch];
        end
        if (pop[ch]) begin
          rd_ptr[ch] <= ~rd_ptr[ch];
        end
        // A push and a pop in the same cycle leave the occupancy unchanged.
        unique case ({push[ch], pop[ch]})
          2'b10:   occ[ch] <= occ[ch] + 2'd1;
          2'b01:   occ[ch] <= occ[ch] - 2'd1;
          default: occ[ch] <= occ[ch];
        endcase
      end
    end
  end

  // The head word comes straight from storage. When a channel is empty, this
  // is whatever the last pop left behind (or 0 after a reset).
  assign left_data   = mem[CH_LEFT][rd_ptr[CH_LEFT]];
  assign right_data  = mem[CH_RIGHT][rd_ptr[CH_RIGHT]];
  assign left_valid  = ch_valid[CH_LEFT];
  assign right_valid = ch_valid[CH_RIGHT];

`ifdef STREAM_DEMUX_COUNT_EN
  // Completed output handshakes per channel. The 8-bit counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      left_count  <= '0;
      right_count <= '0;
    end else begin
      if (pop[CH_LEFT])  left_count  <= left_count + 8'd1;
      if (pop[CH_RIGHT]) right_count <= right_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//
// Self-checking bench for stream_demux. The reference model is a pair of
// unbounded queues: a word joins its channel queue when the channel holds fewer
// than two words, and it leaves from the head on a consumer handshake. A
// compare process checks the DUT against the model on every falling edge.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] left_data;
  logic             left_valid;
  logic             left_ready = 1'b0;
  logic [WIDTH-1:0] right_data;
  logic             right_valid;
  logic             right_ready = 1'b0;
`ifdef STREAM_DEMUX_COUNT_EN
  logic [7:0]       left_count;
  logic [7:0]       right_count;
`endif

  stream_demux #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .left_data   (left_data),
    .left_valid  (left_valid),
    .left_ready  (left_ready),
    .right_data  (right_data),
    .right_valid (right_valid),
    .right_ready (right_ready)
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    .left_count  (left_count),
    .right_count (right_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one queue per channel. popped_* logs every delivered word.
  // ---------------------------------------------------------------------------
  logic [7:0] lq[$];
  logic [7:0] rq[$];
  logic [7:0] popped_l[$];
  logic [7:0] popped_r[$];
  int         model_lcnt = 0;
  int         model_rcnt = 0;
  bit         model_live = 1'b0;

  always @(posedge clk) begin
    bit acc;
    if (!reset_n) begin
      lq.delete();
      rq.delete();
      model_lcnt = 0;
      model_rcnt = 0;
      model_live = 1'b1;
    end else begin
      // Acceptance uses the occupancy from before this edge.
      acc = in_valid && ((in_sel ? rq.size() : lq.size()) < 2);
      if (left_ready && lq.size() != 0) begin
        popped_l.push_back(lq.pop_front());
        model_lcnt = (model_lcnt + 1) % 256;
      end
      if (right_ready && rq.size() != 0) begin
        popped_r.push_back(rq.pop_front());
        model_rcnt = (model_rcnt + 1) % 256;
      end
      if (acc) begin
        if (in_sel) rq.push_back(in_data);
        else        lq.push_back(in_data);
      end
    end
  end

  // Compare process. It samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("left_valid",  {31'd0, left_valid},  {31'd0, lq.size() != 0});
      check("right_valid", {31'd0, right_valid}, {31'd0, rq.size() != 0});
      if (lq.size() != 0) check("left_data",  {24'd0, left_data},  {24'd0, lq[0]});
      if (rq.size() != 0) check("right_data", {24'd0, right_data}, {24'd0, rq[0]});
      check("in_ready", {31'd0, in_ready},
            {31'd0, ((in_sel ? rq.size() : lq.size()) < 2)});
`ifdef STREAM_DEMUX_COUNT_EN
      check("left_count",  {24'd0, left_count},  model_lcnt);
      check("right_count", {24'd0, right_count}, model_rcnt);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Driver. The task is called just after a falling edge. It drives the inputs,
  // samples in_ready once they have settled, then returns just after the next
  // falling edge.
  // ---------------------------------------------------------------------------
  logic last_in_ready;

  task automatic cycle(input logic v, input logic sel, input logic [7:0] d,
                       input logic lr, input logic rr);
    #1;
    in_valid    = v;
    in_sel      = sel;
    in_data     = d;
    left_ready  = lr;
    right_ready = rr;
    #2;
    last_in_ready = in_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int base_l;
    int base_r;

    // ---------------- Reset state ----------------
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst in_ready",    {31'd0, in_ready},    32'd1);
    check("rst left_valid",  {31'd0, left_valid},  32'd0);
    check("rst right_valid", {31'd0, right_valid}, 32'd0);
    check("rst left_data",   {24'd0, left_data},   32'd0);
    check("rst right_data",  {24'd0, right_data},  32'd0);
    #1;
    reset_n = 1'b1;

    // ---------------- Basic steering ----------------
    cycle(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
    check("t1 ready0",      {31'd0, last_in_ready}, 32'd1);
    check("t1 left_valid",  {31'd0, left_valid},    32'd1);
    check("t1 left_data",   {24'd0, left_data},     32'h11);
    cycle(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    check("t1 ready1",      {31'd0, last_in_ready}, 32'd1);
    check("t1 right_valid", {31'd0, right_valid},   32'd1);
    check("t1 right_data",  {24'd0, right_data},    32'h22);
    check("t1 left drained",{31'd0, left_valid},    32'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("t1 right drained", {31'd0, right_valid}, 32'd0);

    // ---------------- Right channel fill and stall ----------------
    base_r = popped_r.size();
    cycle(1'b1, 1'b1, 8'hA1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'hA2, 1'b1, 1'b0);
    check("t2 A2 accepted", {31'd0, last_in_ready}, 32'd1);
    cycle(1'b1, 1'b1, 8'hA3, 1'b1, 1'b0);
    check("t2 A3 refused",  {31'd0, last_in_ready}, 32'd0);
    check("t2 head A1",     {24'd0, right_data},    32'hA1);
    cycle(1'b1, 1'b1, 8'hA3, 1'b1, 1'b0);
    check("t2 head stable", {24'd0, right_data},    32'hA1);
    // A full channel that pops this cycle still refuses the word.
    cycle(1'b1, 1'b1, 8'hA3, 1'b1, 1'b1);
    check("t2 no passthru", {31'd0, last_in_ready}, 32'd0);
    check("t2 head A2",     {24'd0, right_data},    32'hA2);
    cycle(1'b1, 1'b1, 8'hA3, 1'b1, 1'b1);
    check("t2 A3 accepted", {31'd0, last_in_ready}, 32'd1);
    check("t2 head A3",     {24'd0, right_data},    32'hA3);
    cycle(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    check("t2 right empty", {31'd0, right_valid},   32'd0);
    check("t2 pop count",   popped_r.size() - base_r, 32'd3);
    if (popped_r.size() - base_r == 3) begin
      check("t2 order0", {24'd0, popped_r[base_r]},   32'hA1);
      check("t2 order1", {24'd0, popped_r[base_r+1]}, 32'hA2);
      check("t2 order2", {24'd0, popped_r[base_r+2]}, 32'hA3);
    end

    // ---------------- Stalled right does not block left ----------------
    cycle(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h5C, 1'b0, 1'b0);
    check("t3 left accept", {31'd0, last_in_ready}, 32'd1);
    check("t3 left_valid",  {31'd0, left_valid},    32'd1);
    check("t3 left_data",   {24'd0, left_data},     32'h5C);
    check("t3 right head",  {24'd0, right_data},    32'hB1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t3 left popped", {31'd0, left_valid},    32'd0);

    // ---------------- Steady state at occupancy 1 ----------------
    cycle(1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
    base_l = popped_l.size();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b1, 1'b0);
      check("t4 in_ready",  {31'd0, last_in_ready}, 32'd1);
      check("t4 left_data", {24'd0, left_data},     32'(8'h40 + i));
    end
    check("t4 pops",      popped_l.size() - base_l, 32'd10);
    check("t4 first pop", {24'd0, popped_l[base_l]}, 32'h30);

    // ---------------- Alternating channels at full rate ----------------
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'(i % 2), 8'(8'hC0 + i), 1'b1, 1'b1);
      check("t5 in_ready", {31'd0, last_in_ready}, 32'd1);
    end

    // ---------------- Mid-operation reset flush ----------------
    cycle(1'b1, 1'b0, 8'hD1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hD2, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hE1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hE2, 1'b0, 1'b0);
    check("t6 left full",  {31'd0, left_valid},  32'd1);
    check("t6 right full", {31'd0, right_valid}, 32'd1);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 8'hEE;
    do_reset();
    in_valid = 1'b0;
    #2;
    check("t6 in_ready",    {31'd0, in_ready},    32'd1);
    check("t6 left_valid",  {31'd0, left_valid},  32'd0);
    check("t6 right_valid", {31'd0, right_valid}, 32'd0);
    check("t6 left_data",   {24'd0, left_data},   32'd0);
    check("t6 right_data",  {24'd0, right_data},  32'd0);
    @(negedge clk);
    base_l = popped_l.size();
    base_r = popped_r.size();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("t6 nothing left",  popped_l.size() - base_l, 32'd0);
    check("t6 nothing right", popped_r.size() - base_r, 32'd0);

`ifdef STREAM_DEMUX_COUNT_EN
    // ---------------- Transfer counters and wrap ----------------
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 257; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("t7 left_count",  {24'd0, left_count},  32'd1);
    check("t7 right_count", {24'd0, right_count}, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Valid/ready 1-to-2 stream demultiplexer for the multifunction barrel shifter datapath. It is the splitting counterpart of the left/right result multiplexer. Each accepted input word carries a select bit and is steered to either the left or the right output channel. Each channel has a 2-entry FIFO, so one channel stalling never blocks the other and a non-stalled stream runs at one word per cycle.

## Interface
- WIDTH, 8, data width of input and both output channels
- clk  input  1  rising-edge clock, the only clock
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- in_data  input  WIDTH  input word
- in_sel  input  1  steering bit: 0 = left channel, 1 = right channel; part of the payload, qualified by in_valid
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word in the selected channel this cycle
- left_data  output  WIDTH  head word of the left FIFO
- left_valid  output  1  left FIFO not empty
- left_ready  input  1  left consumer accepts the head word
- right_data  output  WIDTH  head word of the right FIFO
- right_valid  output  1  right FIFO not empty
- right_ready  input  1  right consumer accepts the head word
- left_count  output  8  left transfers completed (present only with STREAM_DEMUX_COUNT_EN)
- right_count  output  8  right transfers completed (present only with STREAM_DEMUX_COUNT_EN)

## Operation
- Each channel has a 2-entry FIFO with a 2-bit occupancy (0..2), a 1-bit read pointer and a 1-bit write pointer.
- Input handshake: a word is accepted when in_valid && in_ready.
- in_ready = occupancy(selected channel) < 2, where the selected channel is the one named by in_sel. in_ready may depend combinationally on in_sel and the current occupancies, and on nothing else.
- When in_valid is 0, in_ready still reflects in_sel. Consumers must not rely on this value.
- Push: the accepted word is written at the selected channel's write pointer, and that occupancy increments.
- Output handshake: a word is popped when X_valid && X_ready, with X_valid = occupancy(X) != 0. The read pointer advances and occupancy decrements.
- Push and pop on the same channel in the same cycle leave occupancy unchanged, and both pointers advance.
- Push to one channel while the other pops: the two channels are independent.
- Full channel (occupancy 2) with a same-cycle pop: in_ready stays 0 for that channel in that cycle. There is no pass-through.
- Empty channel: X_data holds the last-popped storage contents and is don't-care. X_valid = 0.
- Word order is preserved within each channel. There is no ordering guarantee between channels.
- No word is dropped, duplicated or reordered within a channel under any ready/valid pattern.
- The output valids never drop without a pop, and X_data is stable while X_valid && !X_ready.

## Timing
- Reset (reset_n = 0 at a rising edge) sets all occupancies and pointers to 0, left_valid/right_valid to 0, FIFO storage (and so left_data/right_data) to 0, and left_count/right_count to 0.
- in_ready is 1 during reset, because it follows occupancy combinationally. Words presented while reset_n = 0 are discarded.
- Reset mid-operation flushes both FIFOs. Outputs are as above in the cycle after the reset edge.
- Latency: a word accepted at edge N appears on X_data with X_valid = 1 after edge N, and can be popped at edge N+1.
- Throughput: one word per cycle per stream when the consumer holds ready = 1.
- Alternating channels can also sustain one input word per cycle.

## Configuration
- STREAM_DEMUX_COUNT_EN defined:
  - left_count/right_count ports exist.
  - Each count increments by 1 on its channel's output handshake.
  - Counts wrap from 255 to 0 and reset to 0.
- STREAM_DEMUX_COUNT_EN undefined: the ports and counter logic are absent, and all other behaviour is identical.

## Test plan
- Reset, then push 0x11 (sel 0), 0x22 (sel 1) with both readies = 1 -> left_data = 0x11, left_valid one cycle after accept; right_data = 0x22 one cycle later; in_ready = 1 throughout.
- right_ready = 0; push 0xA1, 0xA2, 0xA3 with sel 1 -> first two accepted; in_ready = 0 for the third; right_data = 0xA1 and stable. Raise right_ready -> 0xA1, 0xA2, 0xA3 popped in order.
- Right channel full and stalled; push 0x5C with sel 0 -> accepted at once; left_valid = 1 next cycle with 0x5C.
- Left occupancy 1 with left_ready = 1 and a sel-0 push each cycle for 10 cycles -> occupancy stays 1; all 10 words appear in order with no gap.
- Fill both channels, assert reset_n = 0 for one edge -> both valids = 0, data = 0, in_ready = 1 next cycle; earlier words never appear.
- STREAM_DEMUX_COUNT_EN: 257 left pops and 3 right pops -> left_count = 1, right_count = 3.
